// File: rtl/fixed_point_accumulator_if.sv
// rtl/fixed_point_accumulator_if.sv - sample stream and shared-adder signals
// master is the accumulator side; slave is the producer/adder side.
interface fixed_point_accumulator_if;
   logic [15:0] sample_in;
   logic        sample_valid;
   logic        sample_ready;
   logic        add_enable;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic [15:0] add_sum;
   logic        add_done;

   modport master (
      input  sample_in, sample_valid, add_sum, add_done,
      output sample_ready, add_enable, add_a, add_b
   );

   modport slave (
      output sample_in, sample_valid, add_sum, add_done,
      input  sample_ready, add_enable, add_a, add_b
   );
endinterface

// File: rtl/fixed_point_accumulator.sv
// rtl/fixed_point_accumulator.sv - accumulates N signed samples through an external enable/done adder
// All outputs are registered; handshake outputs are derived from the next state.
module fixed_point_accumulator #(
   parameter int N_SAMPLES = 16,
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 15
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   fixed_point_accumulator_if.master        bus,
   output logic [15:0]                      acc_out,
   output logic                             acc_valid,
   output logic                             busy,
   output logic                             error
);

   typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       acc;
   logic [CNT_W-1:0]  cnt;
   logic [7:0]        timer;

   logic clear;
   logic capture;
   logic load_sum;
   logic finish;
   logic abort;
   logic last_sample;
   logic timed_out;

   assign last_sample = (cnt == CNT_W'(N_SAMPLES - 1));
   // timer is 0 in the first WAIT cycle; aborting at TIMEOUT-2 makes error visible TIMEOUT cycles after add_enable
   assign timed_out   = (timer == 8'(TIMEOUT - 2));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      clear     = 1'b0;
      capture   = 1'b0;
      load_sum  = 1'b0;
      finish    = 1'b0;
      abort     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               clear     = 1'b1;
               state_nxt = ACCEPT;
            end
         end
         ACCEPT: begin
            if (bus.sample_valid) begin
               capture   = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.add_done) begin
               load_sum = 1'b1;
               if (last_sample) begin
                  finish    = 1'b1;
                  state_nxt = DONE;
               end else begin
                  state_nxt = ACCEPT;
               end
            end else if (timed_out) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc              <= '0;
         cnt              <= '0;
         timer            <= '0;
         bus.sample_ready <= 1'b0;
         bus.add_enable   <= 1'b0;
         bus.add_a        <= '0;
         bus.add_b        <= '0;
         acc_out          <= '0;
         acc_valid        <= 1'b0;
         busy             <= 1'b0;
         error            <= 1'b0;
      end else begin
         bus.sample_ready <= (state_nxt == ACCEPT);
         bus.add_enable   <= (state_nxt == ISSUE);
         busy             <= (state_nxt != IDLE);
         acc_valid        <= finish;

         if (clear) begin
            acc   <= '0;
            cnt   <= '0;
            error <= 1'b0;
         end

         if (capture) begin
            bus.add_a <= acc;
            bus.add_b <= bus.sample_in;
         end

         if (state == ISSUE) begin
            timer <= '0;
         end else if (state == WAIT) begin
            timer <= timer + 8'd1;
         end

         if (load_sum) begin
            acc <= bus.add_sum;
            if (!last_sample) begin
               cnt <= cnt + CNT_W'(1);
            end
         end

         // acc_out and acc_valid land together, one cycle after the final add_done
         if (finish) begin
            acc_out <= bus.add_sum;
         end

         if (abort) begin
            error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// tb/tb_fixed_point_accumulator.sv - table-driven scoreboard bench for fixed_point_accumulator
// dut4 runs N=4 sequences; dut2 (N=2) shares the sample stream for the wrap case.
module tb_fixed_point_accumulator;

   localparam int TIMEOUT = 6;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic start2;
   logic [15:0] acc_out, acc_out2;
   logic acc_valid, acc_valid2;
   logic busy, busy2;
   logic error, error2;

   fixed_point_accumulator_if bus ();
   fixed_point_accumulator_if bus2 ();

   assign bus2.sample_in    = bus.sample_in;
   assign bus2.sample_valid = bus.sample_valid;

   fixed_point_accumulator #(.N_SAMPLES(4), .CNT_W(16), .TIMEOUT(TIMEOUT)) dut4 (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .acc_out(acc_out), .acc_valid(acc_valid), .busy(busy), .error(error)
   );

   fixed_point_accumulator #(.N_SAMPLES(2), .CNT_W(16), .TIMEOUT(TIMEOUT)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .bus(bus2),
      .acc_out(acc_out2), .acc_valid(acc_valid2), .busy(busy2), .error(error2)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // adder model: add_done arrives lat cycles after add_enable; lat==0 never answers
   int lat = 2;
   int cd = 0, cd2 = 0;
   logic [15:0] pend, pend2;

   always @(posedge clk) begin
      bus.add_done <= 1'b0;
      if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1) begin
            bus.add_done <= 1'b1;
            bus.add_sum  <= pend;
         end
      end
      if (bus.add_enable && lat != 0) begin
         cd   <= lat - 1;
         pend <= bus.add_a + bus.add_b;
      end
   end

   always @(posedge clk) begin
      bus2.add_done <= 1'b0;
      if (cd2 > 0) begin
         cd2 <= cd2 - 1;
         if (cd2 == 1) begin
            bus2.add_done <= 1'b1;
            bus2.add_sum  <= pend2;
         end
      end
      if (bus2.add_enable && lat != 0) begin
         cd2   <= lat - 1;
         pend2 <= bus2.add_a + bus2.add_b;
      end
   end

   logic [15:0] sb[$];
   logic [15:0] sb2[$];
   logic prev_done = 1'b0, prev_done2 = 1'b0;

   always @(negedge clk) begin
      if (acc_valid) begin
         check("acc_valid_latency", 64'(prev_done), 64'd1);
         if (sb.size() == 0) check("unexpected_acc_valid", 64'(acc_out), 64'hFFFF_FFFF);
         else check("acc_out", 64'(acc_out), 64'(sb.pop_front()));
      end
      if (acc_valid2) begin
         check("acc_valid2_latency", 64'(prev_done2), 64'd1);
         if (sb2.size() == 0) check("unexpected_acc_valid2", 64'(acc_out2), 64'hFFFF_FFFF);
         else check("acc_out2", 64'(acc_out2), 64'(sb2.pop_front()));
      end
      prev_done  = bus.add_done;
      prev_done2 = bus2.add_done;
   end

   typedef struct {
      logic [3:0][15:0] s;
      int               gap;
      int               lat;
      bit               poke;
      bit               use2;
      logic [15:0]      exp;
      logic [15:0]      exp2;
   } vec_t;

   function automatic vec_t mk(input logic [15:0] s0, s1, s2, s3, input int gap, l,
                               input bit poke, use2, input logic [15:0] exp, exp2);
      vec_t v;
      v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
      v.gap = gap; v.lat = l; v.poke = poke; v.use2 = use2;
      v.exp = exp; v.exp2 = exp2;
      return v;
   endfunction

   logic [15:0] model_acc;

   task automatic feed(input logic [15:0] s, input int gap, input bit poke, output bit ok);
      int guard = 0;
      ok = 1'b1;
      bus.sample_valid = 1'b1;
      bus.sample_in    = 16'hDEAD;
      while (!bus.sample_ready && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("ready_seen", 64'(bus.sample_ready), 64'd1);
      if (!bus.sample_ready) begin
         bus.sample_valid = 1'b0;
         ok = 1'b0;
         return;
      end
      bus.sample_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         start = poke && (g == 0);
         @(negedge clk);
         start = 1'b0;
         check("backpressure", 64'({bus.sample_ready, bus.add_enable, busy}), 64'b101);
      end
      bus.sample_valid = 1'b1;
      bus.sample_in    = s;
      @(negedge clk);
      bus.sample_valid = 1'b0;
      bus.sample_in    = 16'h0000;
      check("issue", 64'({bus.add_enable, bus.sample_ready, bus.add_a, bus.add_b}),
            64'({1'b1, 1'b0, model_acc, s}));
      model_acc = model_acc + s;
   endtask

   task automatic run_vec(input vec_t v);
      bit ok;
      int guard = 0;
      lat    = v.lat;
      start  = 1'b1;
      start2 = v.use2;
      sb.push_back(v.exp);
      if (v.use2) sb2.push_back(v.exp2);
      model_acc = 16'h0000;
      @(negedge clk);
      start  = 1'b0;
      start2 = 1'b0;
      check("start_busy_err", 64'({busy, error}), 64'b10);
      for (int i = 0; i < 4; i++) begin
         feed(v.s[i], v.gap, v.poke, ok);
         if (!ok) return;
      end
      while (!acc_valid && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      check("acc_valid_seen", 64'(acc_valid), 64'd1);
      if (v.poke) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_after", 64'({busy, error, bus.sample_ready}), 64'd0);
      if (v.use2) check("dut2_idle", 64'({busy2, error2}), 64'd0);
   endtask

   vec_t vecs[5];

   initial begin
      bit ok;
      int cyc;
      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      bus.sample_valid = 1'b0; bus.sample_in = 16'h0000;
      vecs[0] = mk(16'h0100, 16'h0200, 16'hFF00, 16'h0050, 0, 2, 0, 0, 16'h0250, 16'h0000);
      vecs[1] = mk(16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 0, 2, 0, 1, 16'h8000, 16'h8000);
      vecs[2] = mk(16'h8000, 16'h8000, 16'h0001, 16'hFFFF, 7, 2, 0, 0, 16'h0000, 16'h0000);
      vecs[3] = mk(16'h1234, 16'h1111, 16'h0001, 16'hF000, 1, TIMEOUT - 1, 0, 0, 16'h1346, 16'h0000);
      vecs[4] = mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2, 3, 1, 0, 16'hFFFC, 16'h0000);

      repeat (3) @(negedge clk);
      check("reset_outs", 64'({bus.sample_ready, bus.add_enable, bus.add_a, bus.add_b,
                               acc_out, acc_valid, busy, error}), 64'd0);
      check("reset_outs2", 64'({bus2.sample_ready, bus2.add_enable, bus2.add_a, bus2.add_b,
                                acc_out2, acc_valid2, busy2, error2}), 64'd0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // adder never answers: error must rise TIMEOUT cycles after add_enable
      lat = 0;
      model_acc = 16'h0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed(16'h0001, 0, 0, ok);
      cyc = 0;
      while (!error && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      check("timeout_cycles", 64'(cyc), 64'(TIMEOUT));
      check("timeout_idle", 64'({busy, bus.sample_ready, bus.add_enable, acc_valid}), 64'd0);
      repeat (3) @(negedge clk);
      check("timeout_sticky", 64'({error, busy}), 64'b10);

      // reset while waiting on the third sample's sum
      lat = 2;
      model_acc = 16'h0000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      feed(16'h1111, 0, 0, ok);
      feed(16'h2222, 0, 0, ok);
      feed(16'h3333, 0, 0, ok);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_midrun", 64'({bus.sample_ready, bus.add_enable, bus.add_a, bus.add_b,
                                 acc_out, acc_valid, busy, error}), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      run_vec(mk(16'h0010, 16'h0010, 16'h0010, 16'h0010, 0, 2, 0, 0, 16'h0040, 16'h0000));

      repeat (4) @(negedge clk);
      check("sb_drained", 64'(sb.size()), 64'd0);
      check("sb2_drained", 64'(sb2.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
